// File: rtl/ls138_sched_pkg.sv
// ============================================================================
// Module   : ls138_sched_pkg
// Desc     : Shared types and constants for the LS138 round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ls138_sched_pkg;

   localparam int SEL_W = 3;
   localparam int N_REQ = 2 ** SEL_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } state_t;

   // Enable triples packed as {G1, G2A_n, G2B_n}
   localparam logic [2:0] ENABLE_ON  = 3'b100;
   localparam logic [2:0] ENABLE_OFF = 3'b011;

   function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
      logic [N_REQ-1:0] oh;
      oh    = '0;
      oh[s] = 1'b1;
      return oh;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ls138_rr_scheduler_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Desc     : Combinational round-robin winner search starting after ptr.
//            LS138_SCHED_PRIO0_EN makes requester 0 win whenever it requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import ls138_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   always_comb begin
      logic [SEL_W-1:0] cand;
      idx  = '0;
      cand = '0;
      any  = |req;
      // Walk from farthest to nearest so the nearest hit after ptr wins
      for (int i = N_REQ; i >= 1; i--) begin
         cand = ptr + i[SEL_W-1:0];
         if (req[cand]) begin
            idx = cand;
         end
      end
`ifdef LS138_SCHED_PRIO0_EN
      if (req[0]) begin
         idx = '0;
      end
`endif
   end

endmodule

`default_nettype wire

// File: rtl/ls138_rr_scheduler.sv
// ============================================================================
// Module   : ls138_rr_scheduler
// Desc     : Round-robin sharing of one 74LS138 decoder among 8 requesters,
//            with bounded bursts and guard gaps. Option: LS138_SCHED_PRIO0_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls138_rr_scheduler
   import ls138_sched_pkg::*;
#(
   parameter int MAX_HOLD  = 16,
   parameter int GUARD_CYC = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [SEL_W-1:0] sel,
   output logic             dec_g1,
   output logic             dec_g2a_n,
   output logic             dec_g2b_n,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_vld
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GRD_W-1:0] gcnt_q, gcnt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [2:0]       en_q, en_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             vld_q, vld_d;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             hold_hit;

   rr_pick u_rr_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign hold_hit = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         ptr_q   <= SEL_W'(N_REQ - 1);
         sel_q   <= '0;
         en_q    <= ENABLE_OFF;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_any) begin
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!req[sel_q] || hold_hit) begin
               state_d = GUARD;
               cnt_d   = '0;
               gcnt_d  = '0;
`ifdef LS138_SCHED_PRIO0_EN
               if (sel_q != '0) begin
                  ptr_d = sel_q;
               end
`else
               ptr_d = sel_q;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GUARD: begin
            if (gcnt_q == GUARD_LAST) begin
               gcnt_d  = '0;
               state_d = pick_any ? GRANT : IDLE;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            gcnt_d  = '0;
         end
      endcase
   end

   // Address loads only on GRANT entry; it never moves while enabled
   always_comb begin
      sel_d = sel_q;
      en_d  = en_q;
      gnt_d = gnt_q;
      vld_d = vld_q;
      if (state_d == GRANT && state_q != GRANT) begin
         sel_d = pick_idx;
         en_d  = ENABLE_ON;
         gnt_d = sel_onehot(pick_idx);
         vld_d = 1'b1;
      end else if (state_d != GRANT) begin
         en_d  = ENABLE_OFF;
         gnt_d = '0;
         vld_d = 1'b0;
      end
   end

   assign sel       = sel_q;
   assign dec_g1    = en_q[2];
   assign dec_g2a_n = en_q[1];
   assign dec_g2b_n = en_q[0];
   assign gnt       = gnt_q;
   assign gnt_vld   = vld_q;

endmodule

`default_nettype wire

// File: tb/tb_ls138_rr_scheduler.sv
// ============================================================================
// Module   : tb_ls138_rr_scheduler
// Desc     : Directed self-checking bench for ls138_rr_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ls138_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [2:0] sel;
   logic       dec_g1, dec_g2a_n, dec_g2b_n;
   logic [7:0] gnt;
   logic       gnt_vld;

   int n_total = 0;
   int n_bad   = 0;

   ls138_rr_scheduler #(.MAX_HOLD(16), .GUARD_CYC(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .sel       (sel),
      .dec_g1    (dec_g1),
      .dec_g2a_n (dec_g2a_n),
      .dec_g2b_n (dec_g2b_n),
      .gnt       (gnt),
      .gnt_vld   (gnt_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
   endtask

   task automatic check_off(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 32'h00);
      check({tag, "_vld"}, 32'(gnt_vld), 32'd0);
      check({tag, "_en"}, {29'd0, dec_g1, dec_g2a_n, dec_g2b_n}, 32'b011);
   endtask

   task automatic check_on(input string tag, input int who);
      check({tag, "_gnt"}, 32'(gnt), 32'(8'h01 << who));
      check({tag, "_sel"}, 32'(sel), 32'(who));
      check({tag, "_vld"}, 32'(gnt_vld), 32'd1);
      check({tag, "_en"}, {29'd0, dec_g1, dec_g2a_n, dec_g2b_n}, 32'b100);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 8'h00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset values
      do_reset();
      check_off("rst");
      check("rst_sel", 32'(sel), 32'd0);

      // Single requester 2, one-cycle latency, drop after a few cycles
      req = 8'h04;
      tick();
      check_on("single", 2);
      repeat (4) tick();
      check_on("single_hold", 2);
      req = 8'h00;
      tick();
      check_off("single_drop");
      check("single_sel_hold", 32'(sel), 32'd2);
      tick();
      check_off("single_guard");
      tick();
      check_off("single_idle");
      check("single_idle_sel", 32'(sel), 32'd2);

      // All requesting: 0..7 then 0, 16-cycle bursts, 1-cycle gaps
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("rr_gnt_k%0d_c%0d", k, c), 32'(gnt), 32'(8'h01 << (k % 8)));
         end
         tick();
         check_off($sformatf("rr_gap_k%0d", k));
      end

      // Single continuous requester: 16 high / 1 low
      do_reset();
      req = 8'h01;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("hold_vld_r%0d_c%0d", r, c), 32'(gnt_vld), 32'd1);
         end
         tick();
         check($sformatf("hold_gap_r%0d", r), 32'(gnt_vld), 32'd0);
      end

      // Reset in the middle of a grant to requester 5
      do_reset();
      req = 8'h20;
      tick();
      check_on("mid_pre", 5);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_off("mid_rst");
      check("mid_rst_sel", 32'(sel), 32'd0);
      rst = 1'b0;
      req = 8'h21;
      tick();
      check_on("mid_post", 0);

      // Granted req drops while another rises: guard still inserted
      req = 8'h20;
      tick();
      check_off("swap_guard");
      tick();
      check_on("swap_next", 5);

      // Arbitration from ptr=2 with requesters 0 and 3 pending
      do_reset();
      req = 8'h04;
      tick();
      check_on("p0_setup", 2);
      req = 8'h09;
      tick();
      check_off("p0_exit");
      tick();
`ifdef LS138_SCHED_PRIO0_EN
      check_on("p0_win", 0);
      req = 8'h08;
      tick();
      check_off("p0_exit2");
      tick();
      check_on("p0_ptr_kept", 3);
`else
      check_on("rr_from2", 3);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
